// File: rtl/mdu_if.sv
// MDU bus: operation request, HI/LO move strobes and result/status readback.
// The CPU side drives requests (master); the divider/multiplier answers (slave).
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One 64-bit accumulator is shared: shift-add for mult/multu, restoring
// shift-subtract for div/divu (remainder in [63:32], quotient in [31:0]).
// Operands are converted to magnitudes on start; signs are re-applied in FIX.
module mdu (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [4:0]  cnt_reg;
    logic [63:0] acc_reg;
    logic [31:0] opnd_reg;     // multiplicand magnitude or divisor magnitude
    logic        is_div_reg;
    logic        neg_q_reg;    // product / quotient must be negated
    logic        neg_r_reg;    // remainder takes the dividend's sign
    logic        b_zero_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        idle_or_done;
    logic        accept;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_iter;

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign idle_or_done = (state_reg == IDLE) || (state_reg == DONE);
    assign accept       = idle_or_done && bus.start;

    // Operand conditioning: magnitudes and signs for the requested op.
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[31];
        b_neg     = signed_op & bus.b[31];
        a_mag     = a_neg ? (32'd0 - bus.a) : bus.a;
        b_mag     = b_neg ? (32'd0 - bus.b) : bus.b;
    end

    // One iteration of either algorithm on the current accumulator.
    always_comb begin
        // Multiply: accumulator low half holds the multiplier, consumed LSB-first.
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        // Divide: shift the next dividend bit into the partial remainder.
        div_trial = acc_reg[63:31];
        div_ge    = (div_trial >= {1'b0, opnd_reg});
        div_diff  = div_trial[31:0] - opnd_reg;
        if (is_div_reg) begin
            acc_iter = {(div_ge ? div_diff : div_trial[31:0]), acc_reg[30:0], div_ge};
        end else begin
            acc_iter = {mul_sum, acc_reg[31:1]};
        end
    end

    // Sign correction and HI/LO placement of the finished result.
    // With a zero divisor the restoring loop naturally leaves quotient all ones
    // and remainder |a|; restoring a's sign on the remainder yields a itself,
    // so only the quotient negation has to be suppressed.
    always_comb begin
        prod_fix = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
        quot_fix = (neg_q_reg && !b_zero_reg) ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
        rem_fix  = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
        if (is_div_reg) begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: 32 CALC cycles, one FIX cycle, one DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = bus.start ? CALC : IDLE;
            CALC:    state_next = (cnt_reg == 5'd31) ? FIX : CALC;
            FIX:     state_next = DONE;
            DONE:    state_next = bus.start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate while calculating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= 5'd0;
            acc_reg    <= 64'd0;
            opnd_reg   <= 32'd0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg    <= 5'd0;
            acc_reg    <= {32'd0, (bus.op[1] ? a_mag : b_mag)};
            opnd_reg   <= bus.op[1] ? b_mag : a_mag;
            is_div_reg <= bus.op[1];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            b_zero_reg <= (bus.b == 32'd0);
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg + 5'd1;
            acc_reg <= acc_iter;
        end
    end

    // HI/LO: result write on leaving FIX; mthi/mtlo only when not busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (state_reg == FIX) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
        end else if (idle_or_done) begin
            if (bus.hi_wr) begin
                hi_reg <= bus.wr_data;
            end
            if (bus.lo_wr) begin
                lo_reg <= bus.wr_data;
            end
        end
    end

    assign bus.busy = (state_reg == CALC) || (state_reg == FIX);
    assign bus.done = (state_reg == DONE);
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a transaction-level reference model predicts
// busy/done/HI/LO every cycle; directed scenarios pin literal results.
module tb_mdu;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mdu_if bus();

    mdu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;
    logic        m_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI,LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: an accepted op keeps the unit busy for 33 edges, then HI/LO
    // take the result and done shows for one cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else begin
            m_done = 1'b0;
            if (bus.hi_wr) m_hi = bus.wr_data;
            if (bus.lo_wr) m_lo = bus.wr_data;
            if (bus.start) begin
                m_left = 33;
                m_pend = ref_op(bus.op, bus.a, bus.b);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
        chk("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
        chk("cyc_hi", bus.hi, m_hi);
        chk("cyc_lo", bus.lo, m_lo);
    end

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.hi_wr   = 1'b0;
        bus.lo_wr   = 1'b0;
        bus.wr_data = 32'd0;
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        int lat;
        int busy_n;
        bit seen;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = k - 1;
            end else if (bus.busy) begin
                busy_n++;
            end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(lat), 32'd33);
            chk({name, "_busy_cycles"}, 32'(busy_n), 32'd33);
            chk({name, "_hi"}, bus.hi, ehi);
            chk({name, "_lo"}, bus.lo, elo);
        end
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", op, a, b, bus.hi, bus.lo);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        int          n_done;
        bit          seen;

        idle_inputs();

        // Model pins against hand-computed values.
        r = ref_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("model_multu", r[31:0], 32'h0000_0001);
        r = ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model_div_ovf", r[31:0], 32'h8000_0000);
        r = ref_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("model_div_rem", r[63:32], 32'hFFFF_FFFF);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        // First edge with reset released accepts the start.
        rst = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7_2");
        run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

        // mtlo in IDLE, then ignored start/mthi while busy.
        bus.lo_wr   = 1'b1;
        bus.wr_data = 32'h0000_1234;
        @(posedge clk); #1;
        bus.lo_wr = 1'b0;
        chk("mtlo_idle", bus.lo, 32'h0000_1234);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.a       = 32'd9;
        bus.b       = 32'd3;
        bus.hi_wr   = 1'b1;
        bus.wr_data = 32'h0000_FFFF;
        @(posedge clk); #1;
        idle_inputs();
        n_done = 0;
        seen   = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (!seen) begin
                    seen = 1'b1;
                    chk("busy_ignore_hi", bus.hi, 32'd0);
                    chk("busy_ignore_lo", bus.lo, 32'd6);
                end
            end
        end
        chk("busy_ignore_done_pulses", 32'(n_done), 32'd1);
        $display("busy-ignore: done pulses=%0d hi=%08h lo=%08h", n_done, bus.hi, bus.lo);
        @(posedge clk); #1;

        // Reset in the 10th CALC cycle aborts the operation.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        $display("abort: busy=%0b done=%0b hi=%08h lo=%08h", bus.busy, bus.done, bus.hi, bus.lo);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "divu_100_7");

        // Randomized traffic, checked by the per-cycle model comparison.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] va;
            logic [31:0] vb;
            va = $urandom;
            vb = $urandom;
            case ($urandom_range(0, 7))
                0: vb = 32'd0;
                1: begin va = 32'h8000_0000; vb = 32'hFFFF_FFFF; end
                2: vb = $urandom_range(1, 15);
                3: va = $urandom_range(0, 255);
                4: vb = 32'h0000_0000 - 32'($urandom_range(1, 9));
                default: ;
            endcase
            bus.start   = ($urandom_range(0, 5) == 0);
            bus.op      = 2'($urandom_range(0, 3));
            bus.a       = va;
            bus.b       = vb;
            bus.hi_wr   = ($urandom_range(0, 9) == 0);
            bus.lo_wr   = ($urandom_range(0, 9) == 0);
            bus.wr_data = $urandom;
            rst         = ($urandom_range(0, 399) != 0);
            if (bus.start && !bus.busy && rst)
                $display("rand start op=%0d a=%08h b=%08h", bus.op, va, vb);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        idle_inputs();
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have no parameters; iteration count is fixed at 32.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst  input  1  Reset; asynchronous, active-low; asserted while 0.
REQ-004 start  input  1  Request a multiply or divide using op, a and b; sampled on the rising edge.
REQ-005 op  input  2  Operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a  input  32  Operand rs: multiplicand or dividend.
REQ-007 b  input  32  Operand rt: multiplier or divisor.
REQ-008 hi_wr  input  1  mthi strobe; loads wr_data into HI.
REQ-009 lo_wr  input  1  mtlo strobe; loads wr_data into LO.
REQ-010 wr_data  input  32  Data for mthi/mtlo.
REQ-011 busy  output  1  Operation in progress; 1 in CALC and FIX.
REQ-012 done  output  1  One-cycle pulse; HI/LO hold the new result.
REQ-013 hi  output  32  HI register, read by mfhi.
REQ-014 lo  output  32  LO register, read by mflo.

Function
REQ-015 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-016 IDLE/DONE with start=1 SHALL go to CALC, capture op, |a|, |b| and the result signs, and clear the 5-bit iteration counter.
- Unsigned ops: magnitudes are the raw operands.
- Signed ops: magnitudes are two's-complement absolute values.
REQ-017 CALC SHALL perform one iteration per cycle for exactly 32 cycles, then go to FIX when the counter reaches 31.
- mult/multu: shift-add into a 64-bit accumulator.
- div/divu: restoring shift-subtract.
REQ-018 FIX SHALL apply the sign correction, write HI/LO on the exiting edge, and go to DONE.
- Signed mult: negate the 64-bit product if sign(a) XOR sign(b).
- Signed div: quotient negated if sign(a) XOR sign(b); remainder takes the sign of a.
REQ-019 DONE SHALL drive done=1 and busy=0 for one cycle, then go to IDLE, or to CALC if start=1.
REQ-020 Latency: start sampled at edge E0 SHALL give busy=1 from E0 to E33, new HI/LO at E33, and done=1 between E33 and E34.
REQ-021 Result placement SHALL be: mult/multu HI=product[63:32], LO=product[31:0]; div/divu LO=quotient, HI=remainder.
REQ-022 Division by zero (b==0) SHALL give LO=32'hFFFF_FFFF and HI=a unmodified, for div and divu, with no sign correction and no exception.
REQ-023 div 32'h8000_0000 / 32'hFFFF_FFFF SHALL give LO=32'h8000_0000 and HI=0, with no exception.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 hi_wr/lo_wr while busy=1 SHALL be ignored, and HI/LO SHALL be stable throughout CALC and FIX.
REQ-026 hi_wr/lo_wr in IDLE or DONE SHALL load wr_data on that edge.
REQ-027 hi_wr/lo_wr together with start in IDLE or DONE SHALL be applied, and the started operation's result SHALL overwrite HI/LO at its FIX edge.
REQ-028 hi and lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-029 While rst=0 the block SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear the accumulator/remainder.
REQ-030 Reset asserted during CALC or FIX SHALL abort the operation with no HI/LO update and no done pulse.
REQ-031 The first rising edge with rst=1 SHALL accept a start.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- multu a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done exactly 33 cycles after start edge; busy=1 for 33 cycles.
- mult a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB (-21).
- div a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); divu a=7 b=2 -> lo=3, hi=1.
- divu a=00000005 b=0 -> lo=FFFFFFFF, hi=00000005; div a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
- lo_wr wr_data=1234 in IDLE -> lo=00001234 next edge; then start multu 2*3, and during CALC pulse start and hi_wr -> both ignored; final hi=0, lo=6 with a single done pulse.
- rst=0 in 10th CALC cycle -> busy=0, done=0, hi=lo=0 immediately; after release, divu 100/7 -> lo=0000000E, hi=00000002.
